// File: rtl/cpu15_pkg.sv
// ---------------------------------------------------------------------------
// cpu15_pkg
// Shared definitions for the 15-bit CPU program path: instruction width,
// program-memory address width and the state encoding of the program loader.
// ---------------------------------------------------------------------------
package cpu15_pkg;

    localparam int INSN_W  = 15;            // instruction word width
    localparam int PADDR_W = 8;             // program-memory address width
    localparam int HI_W    = INSN_W - 8;    // bits carried by the high byte

    // Loader session states. BUSY covers HI, LO and WR.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } ld_state_t;

endpackage : cpu15_pkg

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Loads a block of 15-bit instruction words into program memory from a host
// byte stream. Each word arrives as two bytes: a high byte (bit 7 must be 0,
// bits 6:0 become word bits 14:8) followed by a low byte (word bits 7:0).
// The word is written one cycle after its low byte transfers, and the address
// advances modulo 256.
//
// Ports
//   CLK_LD      in   sole clock, rising edge
//   RESET       in   synchronous active-high reset
//   LD_START    in   one-cycle pulse, starts a session from IDLE/DONE/ERR
//   LD_BASE     in   first write address, sampled with LD_START
//   LD_LEN      in   word count (0..255), sampled with LD_START
//   LD_DATA     in   host byte
//   LD_VALID    in   LD_DATA valid this cycle
//   LD_READY    out  loader accepts a byte this cycle (HI and LO only)
//   PRAM_WE     out  program-memory write strobe, one cycle per word
//   PRAM_ADDR   out  write address (holds last value outside WR)
//   PRAM_WDATA  out  write data    (holds last value outside WR)
//   LD_BUSY     out  session in progress
//   LD_DONE     out  last session completed
//   LD_ERR      out  last session aborted on a framing error
// ---------------------------------------------------------------------------
module prog_loader
    import cpu15_pkg::*;
(
    input  logic               CLK_LD,
    input  logic               RESET,
    input  logic               LD_START,
    input  logic [PADDR_W-1:0] LD_BASE,
    input  logic [7:0]         LD_LEN,
    input  logic [7:0]         LD_DATA,
    input  logic               LD_VALID,
    output logic               LD_READY,
    output logic               PRAM_WE,
    output logic [PADDR_W-1:0] PRAM_ADDR,
    output logic [INSN_W-1:0]  PRAM_WDATA,
    output logic               LD_BUSY,
    output logic               LD_DONE,
    output logic               LD_ERR
);

    ld_state_t          state_q, state_d;
    logic [PADDR_W-1:0] addr_q;         // address of the word being assembled
    logic [7:0]         count_q;        // words still to be written
    logic [HI_W-1:0]    hi_q;           // high part of the word in flight
    logic [PADDR_W-1:0] pram_addr_q;    // presented address, held between writes
    logic [INSN_W-1:0]  pram_wdata_q;   // presented data, held between writes

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned and infers a latch.
        state_d  = state_q;
        LD_READY = 1'b0;
        PRAM_WE  = 1'b0;
        LD_BUSY  = 1'b0;
        LD_DONE  = 1'b0;
        LD_ERR   = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                LD_DONE = (state_q == S_DONE);
                LD_ERR  = (state_q == S_ERR);
                // A zero-length session completes without touching memory.
                if (LD_START)
                    state_d = (LD_LEN == 8'd0) ? S_DONE : S_HI;
            end
            S_HI: begin
                LD_READY = 1'b1;
                LD_BUSY  = 1'b1;
                // A set bit 7 in the high byte is a framing error.
                if (LD_VALID)
                    state_d = LD_DATA[7] ? S_ERR : S_LO;
            end
            S_LO: begin
                LD_READY = 1'b1;
                LD_BUSY  = 1'b1;
                if (LD_VALID)
                    state_d = S_WR;
            end
            S_WR: begin
                PRAM_WE = 1'b1;
                LD_BUSY = 1'b1;
                // count_q still holds the pre-decrement value here.
                state_d = (count_q == 8'd1) ? S_DONE : S_HI;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign PRAM_ADDR  = pram_addr_q;
    assign PRAM_WDATA = pram_wdata_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_LD) begin
        // NOTE: reset lives inside the clocked branch, so it is synchronous
        // and overrides any LD_START arriving on the same edge.
        if (RESET) begin
            // NOTE: non-blocking assignments throughout, so every register
            // sees the pre-edge value of every other one.
            state_q      <= S_IDLE;
            addr_q       <= '0;
            count_q      <= '0;
            hi_q         <= '0;
            pram_addr_q  <= '0;
            pram_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (LD_START) begin
                        addr_q  <= LD_BASE;
                        count_q <= LD_LEN;
                    end
                end
                S_HI: begin
                    if (LD_VALID && !LD_DATA[7])
                        hi_q <= LD_DATA[HI_W-1:0];
                end
                S_LO: begin
                    // Load the presented address/data as the low byte lands,
                    // so both are valid throughout WR and then simply hold.
                    if (LD_VALID) begin
                        pram_addr_q  <= addr_q;
                        pram_wdata_q <= {hi_q, LD_DATA};
                    end
                end
                S_WR: begin
                    addr_q  <= addr_q + 8'd1;
                    count_q <= count_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Directed bench for prog_loader. Expected writes (address, word) are pushed
// to a scoreboard queue as stimulus is driven; a negedge monitor pops and
// compares them whenever PRAM_WE is seen.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    logic        CLK_LD = 1'b0;
    logic        RESET = 1'b1;
    logic        LD_START = 1'b0;
    logic [7:0]  LD_BASE = '0;
    logic [7:0]  LD_LEN = '0;
    logic [7:0]  LD_DATA = '0;
    logic        LD_VALID = 1'b0;
    logic        LD_READY;
    logic        PRAM_WE;
    logic [7:0]  PRAM_ADDR;
    logic [14:0] PRAM_WDATA;
    logic        LD_BUSY;
    logic        LD_DONE;
    logic        LD_ERR;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    logic [22:0] sb[$];     // {addr, word}

    prog_loader dut (
        .CLK_LD     (CLK_LD),
        .RESET      (RESET),
        .LD_START   (LD_START),
        .LD_BASE    (LD_BASE),
        .LD_LEN     (LD_LEN),
        .LD_DATA    (LD_DATA),
        .LD_VALID   (LD_VALID),
        .LD_READY   (LD_READY),
        .PRAM_WE    (PRAM_WE),
        .PRAM_ADDR  (PRAM_ADDR),
        .PRAM_WDATA (PRAM_WDATA),
        .LD_BUSY    (LD_BUSY),
        .LD_DONE    (LD_DONE),
        .LD_ERR     (LD_ERR)
    );

    always #5 CLK_LD = ~CLK_LD;
    always @(posedge CLK_LD) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every write must match the oldest expected entry;
    // no write may coincide with a byte-accepting state.
    always @(negedge CLK_LD) begin
        if (LD_BUSY)
            check("we_during_hi_lo", {31'd0, PRAM_WE & LD_READY}, 32'd0);
        if (PRAM_WE) begin
            wr_cnt++;
            check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0)
                check("write_addr_data", {9'd0, PRAM_ADDR, PRAM_WDATA}, {9'd0, sb.pop_front()});
        end
    end

    task automatic expect_write(input logic [7:0] a, input logic [14:0] w);
        sb.push_back({a, w});
    endtask

    task automatic start(input logic [7:0] base, input logic [7:0] len);
        LD_START = 1'b1;
        LD_BASE  = base;
        LD_LEN   = len;
        @(posedge CLK_LD); #1;
        LD_START = 1'b0;
    endtask

    // Present a byte and hold it until a transfer happens (bounded).
    // LD_VALID is left high so back-to-back calls stream without gaps.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        LD_DATA  = b;
        LD_VALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK_LD);
            if (LD_READY) begin
                @(posedge CLK_LD); #1;
                ok = 1'b1;
                break;
            end
        end
        check("byte_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic gap();
        LD_VALID = 1'b0;
        @(posedge CLK_LD); #1;
    endtask

    task automatic wait_done(output int cycles, input int c0);
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK_LD);
            if (LD_DONE) break;
        end
        cycles = cyc - c0;
        check("done_seen", {31'd0, LD_DONE}, 32'd1);
    endtask

    initial begin
        int c0, cycles, w0;

        // ---------------- reset with a simultaneous LD_START ------------
        LD_START = 1'b1;
        LD_LEN   = 8'd2;
        repeat (2) @(posedge CLK_LD);
        @(negedge CLK_LD);
        check("rst_ready", {31'd0, LD_READY}, 32'd0);
        check("rst_we",    {31'd0, PRAM_WE},  32'd0);
        check("rst_busy",  {31'd0, LD_BUSY},  32'd0);
        check("rst_done",  {31'd0, LD_DONE},  32'd0);
        check("rst_err",   {31'd0, LD_ERR},   32'd0);
        check("rst_addr",  {24'd0, PRAM_ADDR},  32'd0);
        check("rst_wdata", {17'd0, PRAM_WDATA}, 32'd0);
        @(posedge CLK_LD); #1;
        RESET = 1'b0;
        LD_START = 1'b0;
        @(negedge CLK_LD);
        check("idle_after_rst", {31'd0, LD_BUSY}, 32'd0);
        @(posedge CLK_LD); #1;

        // ---------------- back-to-back, 2 words ------------------------
        expect_write(8'h00, 15'h4800);
        expect_write(8'h01, 15'h4801);
        start(8'h00, 8'd2);
        c0 = cyc;
        send_byte(8'h48); send_byte(8'h00);
        send_byte(8'h48); send_byte(8'h01);
        LD_VALID = 1'b0;
        wait_done(cycles, c0);
        check("b2b_cycles", cycles, 32'd6);
        check("b2b_err", {31'd0, LD_ERR}, 32'd0);
        check("b2b_ready_in_done", {31'd0, LD_READY}, 32'd0);
        check("b2b_sb_empty", sb.size(), 32'd0);

        // ---------------- same session, LD_VALID toggling ---------------
        expect_write(8'h00, 15'h4800);
        expect_write(8'h01, 15'h4801);
        start(8'h00, 8'd2);
        c0 = cyc;
        send_byte(8'h48); gap(); send_byte(8'h00); gap();
        send_byte(8'h48); gap(); send_byte(8'h01);
        LD_VALID = 1'b0;
        wait_done(cycles, c0);
        check("tog_sb_empty", sb.size(), 32'd0);
        check("tog_addr_hold",  {24'd0, PRAM_ADDR},  32'h01);
        check("tog_wdata_hold", {17'd0, PRAM_WDATA}, 32'h4801);

        // ---------------- address wrap ---------------------------------
        expect_write(8'hFE, 15'h1234);
        expect_write(8'hFF, 15'h7FFF);
        expect_write(8'h00, 15'h0001);
        start(8'hFE, 8'd3);
        c0 = cyc;
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h7F); send_byte(8'hFF);
        send_byte(8'h00); send_byte(8'h01);
        LD_VALID = 1'b0;
        wait_done(cycles, c0);
        check("wrap_cycles", cycles, 32'd9);
        check("wrap_sb_empty", sb.size(), 32'd0);

        // ---------------- zero length ----------------------------------
        w0 = wr_cnt;
        start(8'h10, 8'd0);
        @(negedge CLK_LD);
        check("len0_done",  {31'd0, LD_DONE},  32'd1);
        check("len0_ready", {31'd0, LD_READY}, 32'd0);
        check("len0_busy",  {31'd0, LD_BUSY},  32'd0);
        repeat (3) @(negedge CLK_LD);
        check("len0_ready_later", {31'd0, LD_READY}, 32'd0);
        check("len0_no_write", wr_cnt - w0, 32'd0);
        check("len0_addr_hold", {24'd0, PRAM_ADDR}, 32'h00);
        @(posedge CLK_LD); #1;

        // ---------------- framing error, then recovery -----------------
        w0 = wr_cnt;
        start(8'h20, 8'd2);
        send_byte(8'h80);
        LD_VALID = 1'b0;
        @(negedge CLK_LD);
        check("err_flag",  {31'd0, LD_ERR},   32'd1);
        check("err_done",  {31'd0, LD_DONE},  32'd0);
        check("err_ready", {31'd0, LD_READY}, 32'd0);
        check("err_busy",  {31'd0, LD_BUSY},  32'd0);
        repeat (2) @(negedge CLK_LD);
        check("err_holds", {31'd0, LD_ERR}, 32'd1);
        check("err_no_write", wr_cnt - w0, 32'd0);
        @(posedge CLK_LD); #1;
        expect_write(8'h20, 15'h0155);
        start(8'h20, 8'd1);
        c0 = cyc;
        @(negedge CLK_LD);
        check("err_cleared", {31'd0, LD_ERR}, 32'd0);
        @(posedge CLK_LD); #1;
        send_byte(8'h01); send_byte(8'h55);
        LD_VALID = 1'b0;
        wait_done(cycles, c0);
        check("recover_err", {31'd0, LD_ERR}, 32'd0);
        check("recover_sb_empty", sb.size(), 32'd0);

        // ---------------- reset mid-session ----------------------------
        w0 = wr_cnt;
        expect_write(8'h30, 15'h2A0B);
        start(8'h30, 8'd2);
        send_byte(8'h2A); send_byte(8'h0B);
        send_byte(8'h11);               // loader now in LO of word 2
        LD_VALID = 1'b0;
        RESET    = 1'b1;
        LD_START = 1'b1;
        LD_BASE  = 8'h55;
        LD_LEN   = 8'd4;
        @(posedge CLK_LD); #1;
        LD_VALID = 1'b1;
        LD_DATA  = 8'h22;
        @(negedge CLK_LD);
        check("mid_rst_ready", {31'd0, LD_READY}, 32'd0);
        check("mid_rst_we",    {31'd0, PRAM_WE},  32'd0);
        check("mid_rst_busy",  {31'd0, LD_BUSY},  32'd0);
        check("mid_rst_done",  {31'd0, LD_DONE},  32'd0);
        check("mid_rst_err",   {31'd0, LD_ERR},   32'd0);
        check("mid_rst_addr",  {24'd0, PRAM_ADDR},  32'd0);
        check("mid_rst_wdata", {17'd0, PRAM_WDATA}, 32'd0);
        @(posedge CLK_LD); #1;
        RESET    = 1'b0;
        LD_START = 1'b0;
        repeat (4) @(negedge CLK_LD);
        check("mid_rst_idle", {31'd0, LD_BUSY}, 32'd0);
        check("mid_rst_one_write", wr_cnt - w0, 32'd1);
        check("final_sb_empty", sb.size(), 32'd0);
        LD_VALID = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_prog_loader
